gpio_wake_ctrl: RTL and testbench

Port controller for the 6-pin GPIO of the pic12f508 core.
- Synchronises external pin states and reports per-pin edge transitions.
- Owns the GPIO output latch and the TRIS register, and composes the read value the core sees.
- Sequences SLEEP and wake-on-pin-change (GP0/GP1/GP3), issuing a wake reset pulse and latching the GPWUF flag.
- Sits between the core's register-file write/read strobes and the pad ring.

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_wake_ctrl_if.sv | 41 ++++
 rtl/gpio_pin_sync.sv | 36 +++
 rtl/gpio_wake_ctrl.sv | 106 ++++++++++
 tb/tb_gpio_wake_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared types and constants for the pic12f508 GPIO port controller.
package gpio_pkg;

    localparam int IO_PINS = 6;
    localparam logic [5:0] GPIO_MASK = 6'h3F;
    localparam logic [5:0] DEF_WAKE_MASK = 6'b001011;
    localparam logic [5:0] DEF_INPUT_ONLY = 6'b001000;

    typedef enum logic [1:0] {
        LOW   = 2'b00,
        HIGH  = 2'b01,
        FLOAT = 2'b10
    } pin_state_t;

    typedef enum logic [1:0] {
        RUN,
        ARM,
        SLEEP,
        WAKE
    } wake_state_t;

    // 2'b11 from the pad ring is treated as a floating pin.
    function automatic pin_state_t to_pin(input logic [1:0] raw);
        pin_state_t p;
        p = FLOAT;
        if (raw == 2'b00) p = LOW;
        if (raw == 2'b01) p = HIGH;
        return p;
    endfunction

endpackage

// File: rtl/gpio_wake_ctrl_if.sv
// Core/pad-side signal bundle of the GPIO port controller.
interface gpio_wake_ctrl_if
    import gpio_pkg::*;
#(
    parameter int N = IO_PINS
);
    logic [2*N-1:0] pin_state;
    logic           gpio_wr_en;
    logic [N-1:0]   gpio_wr_data;
    logic           tris_wr_en;
    logic [N-1:0]   tris_wr_data;
    logic           gpwu_n;
    logic           sleep_req;
    logic           gpwuf_clr;
    logic [N-1:0]   gpio_rd_data;
    logic [N-1:0]   pin_oe;
    logic [N-1:0]   pin_out;
    logic [N-1:0]   posedge_o;
    logic [N-1:0]   negedge_o;
    logic           sleeping;
    logic           wake_rst;
    logic           gpwuf;

    modport master (
        output pin_state, gpio_wr_en, gpio_wr_data,
        output tris_wr_en, tris_wr_data,
        output gpwu_n, sleep_req, gpwuf_clr,
        input  gpio_rd_data, pin_oe, pin_out,
        input  posedge_o, negedge_o,
        input  sleeping, wake_rst, gpwuf
    );

    modport slave (
        input  pin_state, gpio_wr_en, gpio_wr_data,
        input  tris_wr_en, tris_wr_data,
        input  gpwu_n, sleep_req, gpwuf_clr,
        output gpio_rd_data, pin_oe, pin_out,
        output posedge_o, negedge_o,
        output sleeping, wake_rst, gpwuf
    );
endinterface

// File: rtl/gpio_pin_sync.sv
// Two-flop synchroniser for one tri-state pin plus high-level edge detect.
module gpio_pin_sync
    import gpio_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] pin,
    output logic       is_high,
    output logic       is_float,
    output logic       rise,
    output logic       fall
);

    pin_state_t s1;
    pin_state_t s2;
    logic       prev_high;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1        <= FLOAT;
            s2        <= FLOAT;
            prev_high <= 1'b0;
        end else begin
            s1        <= to_pin(pin);
            s2        <= s1;
            prev_high <= is_high;
        end
    end

    // Only transitions into or out of HIGH are edges; LOW<->FLOAT is silent.
    assign is_high  = (s2 == HIGH);
    assign is_float = (s2 == FLOAT);
    assign rise     = is_high & ~prev_high;
    assign fall     = ~is_high & prev_high;

endmodule

// File: rtl/gpio_wake_ctrl.sv
// GPIO latch/TRIS, read composition and SLEEP/wake-on-change sequencing.
module gpio_wake_ctrl
#(
    parameter int               IO_PINS     = gpio_pkg::IO_PINS,
    parameter int               WAKE_CYCLES = 4,
    parameter logic [IO_PINS-1:0] WAKE_MASK  = gpio_pkg::DEF_WAKE_MASK,
    parameter logic [IO_PINS-1:0] INPUT_ONLY = gpio_pkg::DEF_INPUT_ONLY
) (
    input logic              clk,
    input logic              rst_n,
    gpio_wake_ctrl_if.slave  bus
);
    import gpio_pkg::*;

    localparam int CW = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    logic [IO_PINS-1:0] latch;
    logic [IO_PINS-1:0] tris;
    logic [IO_PINS-1:0] rd;
    logic [IO_PINS-1:0] high_mask;
    logic [IO_PINS-1:0] float_mask;
    logic [IO_PINS-1:0] rise;
    logic [IO_PINS-1:0] fall;
    logic [IO_PINS-1:0] snapshot;
    logic [IO_PINS-1:0] snapshot_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic               gpwuf;
    logic               wake_hit;
    logic               wr_ok;
    wake_state_t        state;
    wake_state_t        state_nxt;

    for (genvar i = 0; i < IO_PINS; i++) begin : g_pin
        gpio_pin_sync u_sync (
            .clk      (clk),
            .rst_n    (rst_n),
            .pin      (bus.pin_state[2*i +: 2]),
            .is_high  (high_mask[i]),
            .is_float (float_mask[i]),
            .rise     (rise[i]),
            .fall     (fall[i])
        );
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        snapshot_nxt = snapshot;
        wake_hit     = 1'b0;
        wr_ok        = (state == RUN);
        unique case (state)
            RUN: begin
                if (bus.sleep_req) state_nxt = ARM;
            end
            ARM: begin
                snapshot_nxt = high_mask;
                state_nxt    = SLEEP;
            end
            SLEEP: begin
                if (!bus.gpwu_n &&
                    |((high_mask ^ snapshot) & WAKE_MASK)) begin
                    state_nxt = WAKE;
                    cnt_nxt   = CW'(WAKE_CYCLES - 1);
                    wake_hit  = 1'b1;
                end
            end
            WAKE: begin
                if (cnt == '0) state_nxt = RUN;
                else cnt_nxt = cnt - 1'b1;
            end
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RUN;
            cnt      <= '0;
            snapshot <= '0;
            latch    <= '0;
            tris     <= '1;
            rd       <= '0;
            gpwuf    <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            snapshot <= snapshot_nxt;
            if (wr_ok && bus.gpio_wr_en) latch <= bus.gpio_wr_data;
            if (wr_ok && bus.tris_wr_en) tris <= bus.tris_wr_data | INPUT_ONLY;
            rd       <= (float_mask & latch) | high_mask;
            // A new wake event takes priority over a clear in the same cycle.
            gpwuf    <= wake_hit | (gpwuf & ~bus.gpwuf_clr);
        end
    end

    assign bus.gpio_rd_data = rd;
    assign bus.pin_oe       = ~tris;
    assign bus.pin_out      = latch;
    assign bus.posedge_o    = rise;
    assign bus.negedge_o    = fall;
    assign bus.sleeping     = (state == ARM) || (state == SLEEP);
    assign bus.wake_rst     = (state == WAKE);
    assign bus.gpwuf        = gpwuf;

endmodule

// File: tb/tb_gpio_wake_ctrl.sv
// Self-checking bench for gpio_wake_ctrl: directed plan plus random traffic.
module tb_gpio_wake_ctrl;

    localparam int N  = 6;
    localparam int WC = 4;
    localparam logic [5:0] WM = 6'b001011;
    localparam logic [5:0] IO = 6'b001000;
    localparam int M_RUN = 0, M_ARM = 1, M_SLEEP = 2, M_WAKE = 3;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail = 0;

    gpio_wake_ctrl_if #(.N(N)) bus ();

    gpio_wake_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [11:0] m_p1, m_s;
    logic [5:0]  m_latch, m_tris, m_rd, m_pos, m_neg, m_snap;
    int          m_mode, m_left;
    logic        m_gpwuf;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] high_of(input logic [11:0] p);
        logic [5:0] h;
        for (int i = 0; i < N; i++) h[i] = (p[2*i +: 2] == 2'b01);
        return h;
    endfunction

    function automatic logic [5:0] float_of(input logic [11:0] p);
        logic [5:0] f;
        for (int i = 0; i < N; i++) f[i] = p[2*i+1];
        return f;
    endfunction

    // Reference behaviour for one clock edge, using the inputs seen there.
    task automatic model_step();
        logic [5:0] hi_old, hi_new;
        logic       woke;
        if (!rst_n) begin
            m_p1 = 12'hAAA; m_s = 12'hAAA;
            m_latch = 0; m_tris = 6'h3F; m_rd = 0;
            m_pos = 0; m_neg = 0; m_snap = 0;
            m_mode = M_RUN; m_left = 0; m_gpwuf = 0;
        end else begin
            hi_old = high_of(m_s);
            woke = 1'b0;
            m_rd = (float_of(m_s) & m_latch) | hi_old;
            case (m_mode)
                M_RUN: begin
                    if (bus.gpio_wr_en) m_latch = bus.gpio_wr_data;
                    if (bus.tris_wr_en) m_tris = bus.tris_wr_data | IO;
                    if (bus.sleep_req) m_mode = M_ARM;
                end
                M_ARM: begin
                    m_snap = hi_old;
                    m_mode = M_SLEEP;
                end
                M_SLEEP: begin
                    if (!bus.gpwu_n && ((hi_old ^ m_snap) & WM) != 0) begin
                        m_mode = M_WAKE;
                        m_left = WC;
                        woke = 1'b1;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_RUN;
                end
            endcase
            if (woke) m_gpwuf = 1'b1;
            else if (bus.gpwuf_clr) m_gpwuf = 1'b0;
            m_s = m_p1;
            m_p1 = bus.pin_state;
            hi_new = high_of(m_s);
            m_pos = hi_new & ~hi_old;
            m_neg = hi_old & ~hi_new;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
        check("rd_data", bus.gpio_rd_data, m_rd);
        check("pin_oe", bus.pin_oe, ~m_tris & 6'h3F);
        check("pin_out", bus.pin_out, m_latch);
        check("posedge", bus.posedge_o, m_pos);
        check("negedge", bus.negedge_o, m_neg);
        check("sleeping", bus.sleeping,
              (m_mode == M_ARM) || (m_mode == M_SLEEP));
        check("wake_rst", bus.wake_rst, m_mode == M_WAKE);
        check("gpwuf", bus.gpwuf, m_gpwuf);
    endtask

    task automatic set_pin(input int i, input logic [1:0] v);
        bus.pin_state[2*i +: 2] = v;
    endtask

    task automatic do_sleep();
        bus.sleep_req = 1'b1;
        cyc();
        bus.sleep_req = 1'b0;
        cyc();
        cyc();
    endtask

    initial begin
        int np, nn, nq, wcnt;
        logic found, seen;
        rst_n = 1'b0;
        bus.pin_state = 12'hAAA;
        bus.gpio_wr_en = 0; bus.gpio_wr_data = 0;
        bus.tris_wr_en = 0; bus.tris_wr_data = 0;
        bus.gpwu_n = 1; bus.sleep_req = 0; bus.gpwuf_clr = 0;
        repeat (3) cyc();
        rst_n = 1'b1;
        cyc();
        check("reset_rd", bus.gpio_rd_data, 0);
        check("reset_oe", bus.pin_oe, 0);
        check("reset_gpwuf", bus.gpwuf, 0);

        bus.gpio_wr_en = 1; bus.gpio_wr_data = 6'h15;
        cyc();
        bus.gpio_wr_en = 0;
        cyc();
        check("latch_float_rd", bus.gpio_rd_data, 6'h15);

        bus.tris_wr_en = 1; bus.tris_wr_data = 6'h00;
        cyc();
        bus.tris_wr_en = 0;
        check("tris_gp3_forced", bus.pin_oe, 6'h37);

        bus.pin_state = {2'b10, 2'b10, 2'b10, 2'b01, 2'b10, 2'b00};
        repeat (3) cyc();
        check("mixed_rd", bus.gpio_rd_data, 6'h14);

        np = 0; nn = 0; nq = 0;
        set_pin(1, 2'b00);
        repeat (3) cyc();
        set_pin(1, 2'b01);
        repeat (5) begin
            cyc(); np += bus.posedge_o[1]; nn += bus.negedge_o[1];
        end
        set_pin(1, 2'b10);
        repeat (5) begin
            cyc(); np += bus.posedge_o[1]; nn += bus.negedge_o[1];
        end
        check("gp1_rise_pulses", np, 1);
        check("gp1_fall_pulses", nn, 1);
        set_pin(4, 2'b00);
        repeat (5) begin
            cyc(); nq += bus.posedge_o[4] + bus.negedge_o[4];
        end
        set_pin(4, 2'b10);
        repeat (5) begin
            cyc(); nq += bus.posedge_o[4] + bus.negedge_o[4];
        end
        check("gp4_lowfloat_none", nq, 0);

        bus.gpwu_n = 0;
        do_sleep();
        check("asleep", bus.sleeping, 1);
        set_pin(3, 2'b01);
        wcnt = 0; seen = 0;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (bus.wake_rst) begin wcnt++; seen = 1; end
            if (seen && !bus.wake_rst && !bus.sleeping) break;
        end
        check("wake_len", wcnt, WC);
        check("wake_flag", bus.gpwuf, 1);
        check("back_run", bus.sleeping, 0);
        bus.gpwuf_clr = 1;
        cyc();
        bus.gpwuf_clr = 0;
        check("flag_clr", bus.gpwuf, 0);

        do_sleep();
        set_pin(5, 2'b01);
        repeat (6) cyc();
        check("gp5_no_wake", bus.sleeping, 1);
        bus.gpwu_n = 1;
        set_pin(0, 2'b01);
        repeat (6) cyc();
        check("gpwu_off_no_wake", bus.sleeping, 1);
        bus.gpio_wr_en = 1; bus.gpio_wr_data = 6'h2A;
        cyc();
        bus.gpio_wr_en = 0;
        check("sleep_wr_ignored", bus.pin_out, 6'h15);
        rst_n = 0;
        cyc();
        rst_n = 1;
        cyc();

        bus.gpwu_n = 0;
        do_sleep();
        set_pin(1, 2'b01);
        found = 0;
        for (int k = 0; k < 20 && !found; k++) begin
            cyc();
            found = bus.wake_rst;
        end
        check("mid_wake_seen", found, 1);
        cyc();
        rst_n = 0;
        cyc();
        rst_n = 1;
        check("trunc_wake_rst", bus.wake_rst, 0);
        check("trunc_gpwuf", bus.gpwuf, 0);
        check("trunc_run", bus.sleeping, 0);
        check("trunc_tris", bus.pin_oe, 0);

        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(3) == 0)
                set_pin($urandom_range(N - 1), 2'($urandom_range(3)));
            bus.gpio_wr_en   = ($urandom_range(3) == 0);
            bus.gpio_wr_data = 6'($urandom);
            bus.tris_wr_en   = ($urandom_range(3) == 0);
            bus.tris_wr_data = 6'($urandom);
            bus.sleep_req    = ($urandom_range(7) == 0);
            bus.gpwu_n       = ($urandom_range(3) == 0);
            bus.gpwuf_clr    = ($urandom_range(9) == 0);
            rst_n            = ($urandom_range(199) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
